// File: rtl/burst_request_arbiter.sv
// Round-robin arbiter granting one burst request per cycle onto a shared AR channel,
// logging {port_id, burst_len} per grant and capping outstanding bursts.
module burst_request_arbiter #(
    parameter int NumPorts         = 2,
    parameter int PortIdWidth      = 1,
    parameter int AddrWidth        = 64,
    parameter int BurstLenWidth    = 8,
    parameter int OutstandingWidth = 6
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [OutstandingWidth-1:0]                  max_outstanding,
    input  logic [NumPorts*(BurstLenWidth+AddrWidth)-1:0] req_dout,
    input  logic [NumPorts-1:0]                          req_empty_n,
    output logic [NumPorts-1:0]                          req_read,
    output logic [AddrWidth-1:0]                         ar_addr,
    output logic [BurstLenWidth-1:0]                     ar_len,
    output logic                                         ar_valid,
    input  logic                                         ar_ready,
    output logic [PortIdWidth+BurstLenWidth-1:0]         order_din,
    input  logic                                         order_full_n,
    output logic                                         order_write,
    input  logic                                         burst_done
);

    localparam int EntryW = BurstLenWidth + AddrWidth;

    logic                        ar_valid_q, ar_valid_d;
    logic [AddrWidth-1:0]        ar_addr_q, ar_addr_d;
    logic [BurstLenWidth-1:0]    ar_len_q, ar_len_d;
    logic [PortIdWidth-1:0]      rr_q, rr_d;
    logic [OutstandingWidth-1:0] outstanding_q, outstanding_d;

    logic                        found;
    logic                        grant;
    logic [PortIdWidth-1:0]      gnt_idx;
    logic [EntryW-1:0]           sel_word;
    logic [BurstLenWidth-1:0]    sel_len;
    logic                        cnt_dec;

    // Winner is the requesting port with the smallest distance from rr, modulo NumPorts.
    always_comb begin
        int best;
        int d;
        found   = 1'b0;
        gnt_idx = '0;
        best    = NumPorts;
        for (int p = 0; p < NumPorts; p++) begin
            d = (p >= int'(rr_q)) ? (p - int'(rr_q)) : (p + NumPorts - int'(rr_q));
            if (req_empty_n[p] && d < best) begin
                best    = d;
                found   = 1'b1;
                gnt_idx = PortIdWidth'(p);
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (int'(gnt_idx) == p) begin
                sel_word = req_dout[p*EntryW +: EntryW];
            end
        end
    end

    assign sel_len = sel_word[EntryW-1 -: BurstLenWidth];

    // ar_ready frees the slot in the same cycle, allowing back-to-back issue.
    assign grant = !rst && found && order_full_n
                   && (!ar_valid_q || ar_ready)
                   && (outstanding_q < max_outstanding);

    assign cnt_dec = burst_done && (outstanding_q != '0);

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            req_read[p] = grant && (int'(gnt_idx) == p);
        end
        order_write = grant;
        order_din   = {gnt_idx, sel_len};
    end

    always_comb begin
        ar_valid_d    = ar_valid_q;
        ar_addr_d     = ar_addr_q;
        ar_len_d      = ar_len_q;
        rr_d          = rr_q;
        outstanding_d = outstanding_q;
        if (grant) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = sel_word[AddrWidth-1:0];
            ar_len_d   = sel_len;
            rr_d       = (int'(gnt_idx) == NumPorts - 1) ? '0 : gnt_idx + 1'b1;
        end else if (ar_valid_q && ar_ready) begin
            ar_valid_d = 1'b0;
        end
        if (grant && !cnt_dec) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!grant && cnt_dec) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid_q    <= 1'b0;
            ar_addr_q     <= '0;
            ar_len_q      <= '0;
            rr_q          <= '0;
            outstanding_q <= '0;
        end else begin
            ar_valid_q    <= ar_valid_d;
            ar_addr_q     <= ar_addr_d;
            ar_len_q      <= ar_len_d;
            rr_q          <= rr_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign ar_valid = ar_valid_q;
    assign ar_addr  = ar_addr_q;
    assign ar_len   = ar_len_q;

endmodule

// File: doc/burst_request_arbiter.md
# burst_request_arbiter

Round-robin arbiter sharing one memory read-address channel among `NumPorts` burst-request streams, each produced by an upstream burst detector as `{burst_len, base_addr}` words. It issues one AXI-style AR request per granted burst and caps the number of outstanding bursts. For each grant it logs `{port_id, burst_len}` into an order FIFO so the read-data demux can return beats to the right requester. It sits between the per-port burst detectors and the memory interface's AR channel.

## Interface
- `NumPorts`, 2: number of requesters, 2..16.
- `PortIdWidth`, 1: width of port index; must equal ceil(log2(NumPorts)), minimum 1.
- `AddrWidth`, 64: byte address width.
- `BurstLenWidth`, 8: burst length field width (beats minus one).
- `OutstandingWidth`, 6: width of outstanding-burst counter and limit.

- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `max_outstanding`  in  OutstandingWidth  limit on issued-but-uncompleted bursts; 0 blocks all grants.
- `req_dout`  in  NumPorts*(BurstLenWidth+AddrWidth)  per-port `{burst_len, addr}`; port i occupies slice i.
- `req_empty_n`  in  NumPorts  per-port request available.
- `req_read`  out  NumPorts  per-port pop, one-hot or zero.
- `ar_addr`  out  AddrWidth  issued burst address.
- `ar_len`  out  BurstLenWidth  issued burst length (beats minus one).
- `ar_valid`  out  1  AR request valid.
- `ar_ready`  in  1  AR accepted when high together with `ar_valid`.
- `order_din`  out  PortIdWidth+BurstLenWidth  `{port_id, burst_len}` of the granted burst.
- `order_full_n`  in  1  order FIFO has space.
- `order_write`  out  1  order FIFO push.
- `burst_done`  in  1  one-cycle pulse per fully returned burst (last R beat).

## Operation
- Issue slot: output register holding `ar_addr`, `ar_len`, `ar_valid`.
  - The slot is free when `!ar_valid`, or when `ar_valid && ar_ready` in the current cycle.
- Grant condition, evaluated in the same cycle: slot free, `order_full_n`, `outstanding < max_outstanding`, and at least one `req_empty_n` bit set.
- Arbitration:
  - Round-robin pointer `rr` (PortIdWidth bits).
  - Search order is `rr`, `rr+1`, …, wrapping modulo `NumPorts` (not modulo 2^PortIdWidth).
  - The first port with `req_empty_n` wins.
  - After a grant to port g, `rr` becomes (g+1) mod NumPorts.
  - `rr` does not change without a grant.
- On a grant to port g:
  - `req_read[g]=1` and `order_write=1` in the same cycle.
  - `order_din = {g, burst_len_g}`.
  - At the next edge: slot loads `{addr_g, burst_len_g}`, `ar_valid` goes to 1, and `outstanding` increments.
- Without a grant:
  - If `ar_valid && ar_ready`, `ar_valid` clears at the next edge.
  - Otherwise the slot holds its contents unchanged; `ar_addr` and `ar_len` are stable while `ar_valid && !ar_ready`.
- Outstanding counter:
  - Grant only: +1. `burst_done` only: −1. Both in the same cycle: unchanged.
  - `burst_done` while `outstanding==0` is ignored; the counter never underflows.
  - If `max_outstanding` is lowered below `outstanding`, the block only stops granting. The counter drains via `burst_done`; no other effect.
- `req_read`, `order_write` and `order_din` are combinational from the registered state and the inputs.
  - There is no combinational path from `req_dout` to `req_read`.
  - `ar_ready` reaches `req_read` combinationally; this path is permitted.

## Timing
- Reset values: `ar_valid=0`, `ar_addr=0`, `ar_len=0`, `rr=0`, `outstanding=0`.
  - `req_read` and `order_write` are forced 0 while `rst` is high.
- Latency: request visible at cycle t, granted at t; `ar_valid` high at t+1.
- Throughput: one grant per cycle when `ar_ready` stays high (back-to-back issue).
- Reset mid-operation:
  - A pending AR request is dropped and the outstanding count is cleared.
  - Upstream and downstream logic is reset by the same `rst`.
- `order_full_n` low blocks grants; a request already in the issue slot still drains.

## Test plan
- Single port 0 request `{len=3, addr=0x1000}`, `ar_ready=1`, `max_outstanding=4` -> `req_read=0b01` and `order_din={0,3}` at t; `ar_valid`, `ar_addr=0x1000`, `ar_len=3` at t+1; `outstanding=1`.
- Both ports continuously non-empty, `ar_ready=1` -> grants alternate 0,1,0,1; one grant per cycle; order FIFO receives port IDs 0,1,0,1.
- `ar_ready=0` for 5 cycles with a request loaded -> `ar_addr`/`ar_len` are stable; no further `req_read`; when `ar_ready` rises, the next grant occurs in that same cycle.
- `max_outstanding=2`, three requests queued, no `burst_done` -> exactly 2 grants then stall. A `burst_done` pulse gives a third grant in the following cycle. `burst_done` coinciding with a grant leaves the count unchanged.
- `order_full_n=0` with requests pending -> no `req_read`, no `order_write`, `rr` unchanged. `max_outstanding=0` -> no grants. `burst_done` at count 0 -> count stays 0.
- `NumPorts=3` with ports 1 and 2 active -> the wrap goes from 2 to 0, never to invalid index 3. Assert `rst` while `ar_valid=1` -> next cycle `ar_valid=0`, `outstanding=0`, `rr=0`.
